// File: rtl/sfr_pkg.sv
// Shared constants and select-index helpers for the SFR forwarding mux.
package sfr_pkg;

  localparam int unsigned SFR_DATA_W     = 8;
  localparam int unsigned SEL_EX_MEM_BOT = 0;

  function automatic int unsigned sel_top_idx(input int unsigned k);
    return 1 + 2 * k;
  endfunction

  function automatic int unsigned sel_bot_idx(input int unsigned k);
    return 2 + 2 * k;
  endfunction

endpackage

// File: rtl/sfr_hist_shreg.sv
// MEM/WB history shift register. Age 0 is the live input; ages 1..HIST_DEPTH-1 are registered.
module sfr_hist_shreg #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned HIST_DEPTH = 2
) (
  input  logic                                  clock,
  input  logic                                  reset_n,
  input  logic                                  advance,
  input  logic                                  flush,
  input  logic [DATA_W-1:0]                     live_top,
  input  logic [DATA_W-1:0]                     live_bot,
  input  logic                                  live_vld,
  output logic [HIST_DEPTH-1:0][DATA_W-1:0]     age_top,
  output logic [HIST_DEPTH-1:0][DATA_W-1:0]     age_bot,
  output logic [HIST_DEPTH-1:0]                 age_vld
);

  assign age_top[0] = live_top;
  assign age_bot[0] = live_bot;
  assign age_vld[0] = live_vld;

  if (HIST_DEPTH > 1) begin : g_hist
    logic [DATA_W-1:0] r_top [1:HIST_DEPTH-1];
    logic [DATA_W-1:0] r_bot [1:HIST_DEPTH-1];
    logic              r_vld [1:HIST_DEPTH-1];

    // Flush only drops valids; data is left in place.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        for (int k = 1; k < HIST_DEPTH; k++) begin
          r_top[k] <= '0;
          r_bot[k] <= '0;
          r_vld[k] <= 1'b0;
        end
      end else if (flush) begin
        for (int k = 1; k < HIST_DEPTH; k++) begin
          r_vld[k] <= 1'b0;
        end
      end else if (advance) begin
        r_top[1] <= live_top;
        r_bot[1] <= live_bot;
        r_vld[1] <= live_vld;
        for (int k = 2; k < HIST_DEPTH; k++) begin
          r_top[k] <= r_top[k-1];
          r_bot[k] <= r_bot[k-1];
          r_vld[k] <= r_vld[k-1];
        end
      end
    end

    for (genvar k = 1; k < HIST_DEPTH; k++) begin : g_age
      assign age_top[k] = r_top[k];
      assign age_bot[k] = r_bot[k];
      assign age_vld[k] = r_vld[k];
    end
  end

endmodule

// File: rtl/sfr_fwd_mux.sv
// SFR write-data forwarding mux: AND-OR select over EX/MEM and MEM/WB history,
// with one-hot validity, sticky multi-select error and optional output register.
module sfr_fwd_mux
  import sfr_pkg::*;
#(
  parameter int unsigned DATA_W     = SFR_DATA_W,
  parameter int unsigned HIST_DEPTH = 2,
  parameter bit          REG_OUT    = 1'b0,
  localparam int unsigned NUM_SEL   = 1 + 2 * HIST_DEPTH
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               advance,
  input  logic               flush,
  input  logic [DATA_W-1:0]  ex_mem_data_bot,
  input  logic [DATA_W-1:0]  mem_wb_data_top,
  input  logic [DATA_W-1:0]  mem_wb_data_bot,
  input  logic               mem_wb_valid,
  input  logic [NUM_SEL-1:0] sel_signals,
  output logic [DATA_W-1:0]  sfr_data_input,
  output logic               sfr_data_valid,
  output logic               sel_multi,
  output logic               sel_err
);

  logic [HIST_DEPTH-1:0][DATA_W-1:0] w_age_top;
  logic [HIST_DEPTH-1:0][DATA_W-1:0] w_age_bot;
  logic [HIST_DEPTH-1:0]             w_age_vld;
  logic [NUM_SEL-1:0][DATA_W-1:0]    w_src;
  logic [NUM_SEL-1:0]                w_src_vld;
  logic [DATA_W-1:0]                 w_data;
  logic                              w_vld;
  logic                              w_sel_any;
  logic                              w_sel_multi;
  logic                              r_sel_err;

  sfr_hist_shreg #(
    .DATA_W     (DATA_W),
    .HIST_DEPTH (HIST_DEPTH)
  ) u_hist (
    .clock    (clock),
    .reset_n  (reset_n),
    .advance  (advance),
    .flush    (flush),
    .live_top (mem_wb_data_top),
    .live_bot (mem_wb_data_bot),
    .live_vld (mem_wb_valid),
    .age_top  (w_age_top),
    .age_bot  (w_age_bot),
    .age_vld  (w_age_vld)
  );

  assign w_src[SEL_EX_MEM_BOT]     = ex_mem_data_bot;
  assign w_src_vld[SEL_EX_MEM_BOT] = 1'b1;

  for (genvar k = 0; k < HIST_DEPTH; k++) begin : g_src
    assign w_src[sel_top_idx(k)]     = w_age_top[k];
    assign w_src[sel_bot_idx(k)]     = w_age_bot[k];
    assign w_src_vld[sel_top_idx(k)] = w_age_vld[k];
    assign w_src_vld[sel_bot_idx(k)] = w_age_vld[k];
  end

  // Plain AND-OR: a multi-hot select yields the OR of the chosen sources.
  always_comb begin
    w_data = '0;
    for (int i = 0; i < NUM_SEL; i++) begin
      w_data = w_data | (w_src[i] & {DATA_W{sel_signals[i]}});
    end
  end

  assign w_sel_any   = |sel_signals;
  assign w_sel_multi = |(sel_signals & (sel_signals - NUM_SEL'(1)));
  assign w_vld       = w_sel_any & ~w_sel_multi & |(sel_signals & w_src_vld);
  assign sel_multi   = w_sel_multi;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sel_err <= 1'b0;
    end else if (w_sel_multi) begin
      r_sel_err <= 1'b1;
    end
  end

  assign sel_err = r_sel_err;

  if (REG_OUT) begin : g_reg_out
    logic [DATA_W-1:0] r_data;
    logic              r_vld;

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        r_data <= '0;
        r_vld  <= 1'b0;
      end else if (flush) begin
        r_data <= w_data;
        r_vld  <= 1'b0;
      end else if (advance) begin
        r_data <= w_data;
        r_vld  <= w_vld;
      end
    end

    assign sfr_data_input = r_data;
    assign sfr_data_valid = r_vld;
  end else begin : g_comb_out
    assign sfr_data_input = w_data;
    assign sfr_data_valid = w_vld;
  end

endmodule

// File: tb/tb_sfr_fwd_mux.sv
// Directed bench: instance A (HIST_DEPTH=2, comb out), instance B (HIST_DEPTH=3, registered out).
module tb_sfr_fwd_mux;

  logic       clock;
  int         n_checks;
  int         n_errors;

  // Instance A
  logic       rst_a, adv_a, flush_a, vld_a;
  logic [7:0] ex_a, top_a, bot_a;
  logic [4:0] sel_a;
  logic [7:0] data_a;
  logic       dvld_a, multi_a, err_a;

  // Instance B
  logic       rst_b, adv_b, flush_b, vld_b;
  logic [7:0] ex_b, top_b, bot_b;
  logic [6:0] sel_b;
  logic [7:0] data_b;
  logic       dvld_b, multi_b, err_b;

  sfr_fwd_mux #(
    .DATA_W     (8),
    .HIST_DEPTH (2),
    .REG_OUT    (1'b0)
  ) u_dut_a (
    .clock           (clock),
    .reset_n         (rst_a),
    .advance         (adv_a),
    .flush           (flush_a),
    .ex_mem_data_bot (ex_a),
    .mem_wb_data_top (top_a),
    .mem_wb_data_bot (bot_a),
    .mem_wb_valid    (vld_a),
    .sel_signals     (sel_a),
    .sfr_data_input  (data_a),
    .sfr_data_valid  (dvld_a),
    .sel_multi       (multi_a),
    .sel_err         (err_a)
  );

  sfr_fwd_mux #(
    .DATA_W     (8),
    .HIST_DEPTH (3),
    .REG_OUT    (1'b1)
  ) u_dut_b (
    .clock           (clock),
    .reset_n         (rst_b),
    .advance         (adv_b),
    .flush           (flush_b),
    .ex_mem_data_bot (ex_b),
    .mem_wb_data_top (top_b),
    .mem_wb_data_bot (bot_b),
    .mem_wb_valid    (vld_b),
    .sel_signals     (sel_b),
    .sfr_data_input  (data_b),
    .sfr_data_valid  (dvld_b),
    .sel_multi       (multi_b),
    .sel_err         (err_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_a = 1'b0; adv_a = 1'b0; flush_a = 1'b0; vld_a = 1'b0;
    ex_a = '0; top_a = '0; bot_a = '0; sel_a = '0;
    rst_b = 1'b0; adv_b = 1'b0; flush_b = 1'b0; vld_b = 1'b0;
    ex_b = '0; top_b = '0; bot_b = '0; sel_b = '0;

    #12;
    check("a_rst_err",    32'(err_a),  32'h0);
    check("a_zero_data",  32'(data_a), 32'h0);
    check("a_zero_vld",   32'(dvld_a), 32'h0);
    check("a_zero_multi", 32'(multi_a), 32'h0);
    check("b_rst_data",   32'(data_b), 32'h0);
    check("b_rst_vld",    32'(dvld_b), 32'h0);
    check("b_rst_err",    32'(err_b),  32'h0);

    @(negedge clock);
    rst_a = 1'b1;
    rst_b = 1'b1;
    tick();

    // A: defaults
    sel_a = 5'b00001; ex_a = 8'hA5; #1;
    check("a_def_data",  32'(data_a),  32'hA5);
    check("a_def_vld",   32'(dvld_a),  32'h1);
    check("a_def_multi", 32'(multi_a), 32'h0);

    // A: history select after reset is invalid
    sel_a = 5'b01000; #1;
    check("a_post_rst_hist_vld", 32'(dvld_a), 32'h0);

    // A: shift
    top_a = 8'h12; bot_a = 8'h34; vld_a = 1'b1; adv_a = 1'b1;
    tick();
    adv_a = 1'b0; top_a = 8'h56; bot_a = 8'h78;
    sel_a = 5'b01000; #1;
    check("a_top1_data", 32'(data_a), 32'h12);
    check("a_top1_vld",  32'(dvld_a), 32'h1);
    sel_a = 5'b00100; #1;
    check("a_bot0_data", 32'(data_a), 32'h78);
    check("a_bot0_vld",  32'(dvld_a), 32'h1);
    vld_a = 1'b0; sel_a = 5'b00010; #1;
    check("a_top0_inv_data", 32'(data_a), 32'h56);
    check("a_top0_inv_vld",  32'(dvld_a), 32'h0);

    // A: stall
    top_a = 8'h12; bot_a = 8'h34; vld_a = 1'b1; adv_a = 1'b1;
    tick();
    adv_a = 1'b0; top_a = 8'hFF; bot_a = 8'hFF;
    tick(); tick(); tick();
    sel_a = 5'b10000; #1;
    check("a_stall_data", 32'(data_a), 32'h34);
    check("a_stall_vld",  32'(dvld_a), 32'h1);

    // A: flush beats advance
    flush_a = 1'b1; adv_a = 1'b1; top_a = 8'hAA; bot_a = 8'hBB;
    tick();
    flush_a = 1'b0; adv_a = 1'b0;
    sel_a = 5'b01000; #1;
    check("a_flush_vld",  32'(dvld_a), 32'h0);
    check("a_flush_data", 32'(data_a), 32'h12);
    sel_a = 5'b10000; #1;
    check("a_flush_bot",  32'(data_a), 32'h34);

    // A: multi-select and sticky error
    sel_a = 5'b00011; ex_a = 8'hF0; top_a = 8'h0F; #1;
    check("a_multi_data",  32'(data_a),  32'hFF);
    check("a_multi_vld",   32'(dvld_a),  32'h0);
    check("a_multi_flag",  32'(multi_a), 32'h1);
    check("a_err_pre",     32'(err_a),   32'h0);
    tick();
    check("a_err_set",     32'(err_a),   32'h1);
    sel_a = 5'b00001; #1;
    check("a_clean_multi", 32'(multi_a), 32'h0);
    check("a_clean_vld",   32'(dvld_a),  32'h1);
    flush_a = 1'b1;
    tick();
    flush_a = 1'b0;
    check("a_err_sticky",  32'(err_a),   32'h1);

    // B: fill history, registered output
    adv_b = 1'b1; vld_b = 1'b1; top_b = 8'h11; bot_b = 8'h22;
    tick();
    top_b = 8'h33; bot_b = 8'h44;
    tick();
    top_b = 8'h55; bot_b = 8'h66;
    sel_b = 7'b0100000; #1;
    check("b_pre_data", 32'(data_b), 32'h0);
    check("b_pre_vld",  32'(dvld_b), 32'h0);
    tick();
    check("b_top2_data", 32'(data_b), 32'h11);
    check("b_top2_vld",  32'(dvld_b), 32'h1);

    // B: output holds while stalled
    adv_b = 1'b0; sel_b = 7'b0000001; ex_b = 8'h77;
    tick();
    check("b_hold_data", 32'(data_b), 32'h11);
    adv_b = 1'b1;
    tick();
    check("b_ex_data", 32'(data_b), 32'h77);
    check("b_ex_vld",  32'(dvld_b), 32'h1);

    // B: multi-select
    sel_b = 7'b0000011; ex_b = 8'h70; top_b = 8'h07; #1;
    check("b_multi_flag", 32'(multi_b), 32'h1);
    tick();
    check("b_multi_data", 32'(data_b), 32'h77);
    check("b_multi_vld",  32'(dvld_b), 32'h0);
    check("b_err_set",    32'(err_b),  32'h1);

    // B: async reset mid-stream
    sel_b = 7'b0000001; tick();
    rst_b = 1'b0; #1;
    check("b_midrst_data", 32'(data_b), 32'h0);
    check("b_midrst_vld",  32'(dvld_b), 32'h0);
    check("b_midrst_err",  32'(err_b),  32'h0);
    @(negedge clock);
    rst_b = 1'b1;
    sel_b = 7'b0100000;
    tick();
    check("b_postrst_vld",  32'(dvld_b), 32'h0);
    check("b_postrst_data", 32'(data_b), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
